mem_wb: RTL and testbench

//  MEM/WB pipeline register of the 5-stage RV32 core, between data memory and writeback.
//  - Captures load data, ALU result, destination register and WB control on every rising clock edge.
//  - Presents the captured values to the writeback stage one cycle later.
//  - Also drives the pre-muxed writeback value and a qualified register-file write enable.

---
 rtl/core_pkg.sv | 10 +
 rtl/mem_wb_pipe_reg.sv | 14 +
 rtl/mem_wb.sv | 46 ++++
 tb/tb_mem_wb.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared widths and the writeback control bundle for the RV32 pipeline registers.
package core_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;
endpackage

// File: rtl/mem_wb_pipe_reg.sv
// Generic D register with asynchronous active-high clear, used for pipeline stages.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= d;
    end
endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: captures MEM-stage results and presents the writeback
// value and a write enable that is suppressed for destination x0.
module mem_wb
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       read_data_in,
    input  logic [XLEN-1:0]       alu_result_in,
    input  logic [REG_ADDR_W-1:0] rd_mem_in,
    input  logic                  reg_write_mem_in,
    input  logic                  mem_to_reg_mem_in,
    output logic [XLEN-1:0]       read_data_out,
    output logic [XLEN-1:0]       alu_result_out,
    output logic [REG_ADDR_W-1:0] rd_mem_out,
    output logic                  reg_write_mem_out,
    output logic                  mem_to_reg_mem_out,
    output logic [XLEN-1:0]       wb_data_out,
    output logic                  wb_en_out
);
    localparam int BUNDLE_W = 2 * XLEN + REG_ADDR_W + $bits(wb_ctrl_t);

    wb_ctrl_t              ctrl_d;
    wb_ctrl_t              ctrl_q;
    logic [BUNDLE_W-1:0]   bundle_d;
    logic [BUNDLE_W-1:0]   bundle_q;

    assign ctrl_d.reg_write  = reg_write_mem_in;
    assign ctrl_d.mem_to_reg = mem_to_reg_mem_in;
    assign bundle_d = {read_data_in, alu_result_in, rd_mem_in, ctrl_d};

    // All fields share one register so reset clears them together.
    pipe_reg #(.W(BUNDLE_W)) u_bundle (
        .clk (clk),
        .rst (rst),
        .d   (bundle_d),
        .q   (bundle_q)
    );

    assign {read_data_out, alu_result_out, rd_mem_out, ctrl_q} = bundle_q;
    assign reg_write_mem_out  = ctrl_q.reg_write;
    assign mem_to_reg_mem_out = ctrl_q.mem_to_reg;

    assign wb_data_out = ctrl_q.mem_to_reg ? read_data_out : alu_result_out;
    assign wb_en_out   = ctrl_q.reg_write && (rd_mem_out != '0);
endmodule

// File: tb/tb_mem_wb.sv
// Bench for mem_wb: history-based reference model, per-cycle compare, directed literal checks.
module tb_mem_wb;
    typedef struct packed {
        logic [31:0] rdat;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] read_data_in = '0;
    logic [31:0] alu_result_in = '0;
    logic [4:0]  rd_mem_in = '0;
    logic        reg_write_mem_in = 1'b0;
    logic        mem_to_reg_mem_in = 1'b0;
    logic [31:0] read_data_out;
    logic [31:0] alu_result_out;
    logic [4:0]  rd_mem_out;
    logic        reg_write_mem_out;
    logic        mem_to_reg_mem_out;
    logic [31:0] wb_data_out;
    logic        wb_en_out;

    int unsigned checks = 0;
    int unsigned errors = 0;

    mem_wb dut (
        .clk                (clk),
        .rst                (rst),
        .read_data_in       (read_data_in),
        .alu_result_in      (alu_result_in),
        .rd_mem_in          (rd_mem_in),
        .reg_write_mem_in   (reg_write_mem_in),
        .mem_to_reg_mem_in  (mem_to_reg_mem_in),
        .read_data_out      (read_data_out),
        .alu_result_out     (alu_result_out),
        .rd_mem_out         (rd_mem_out),
        .reg_write_mem_out  (reg_write_mem_out),
        .mem_to_reg_mem_out (mem_to_reg_mem_out),
        .wb_data_out        (wb_data_out),
        .wb_en_out          (wb_en_out)
    );

    always #5 clk = ~clk;

    // Model: what was offered at each rising edge; a reset seen since then voids the last entry.
    txn_t hist[$];
    bit   reset_since_edge = 1'b1;

    always @(posedge clk) begin
        txn_t t;
        t = '{rdat: read_data_in, alu: alu_result_in, rd: rd_mem_in,
              rw: reg_write_mem_in, m2r: mem_to_reg_mem_in};
        hist.push_back(rst ? txn_t'('0) : t);
        if (hist.size() > 16) void'(hist.pop_front());
        reset_since_edge = rst;
    end

    always @(posedge rst) reset_since_edge = 1'b1;

    function automatic txn_t expected();
        if (rst || reset_since_edge || hist.size() == 0) return '0;
        return hist[$];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input txn_t e);
        chk({tag, ".read_data"},  read_data_out, e.rdat);
        chk({tag, ".alu_result"}, alu_result_out, e.alu);
        chk({tag, ".rd"},         {27'd0, rd_mem_out}, {27'd0, e.rd});
        chk({tag, ".reg_write"},  {31'd0, reg_write_mem_out}, {31'd0, e.rw});
        chk({tag, ".mem_to_reg"}, {31'd0, mem_to_reg_mem_out}, {31'd0, e.m2r});
        chk({tag, ".wb_data"},    wb_data_out, e.m2r ? e.rdat : e.alu);
        chk({tag, ".wb_en"},      {31'd0, wb_en_out}, {31'd0, (e.rw && e.rd != 0)});
    endtask

    // Per-cycle compare against the model, 1 ns after each rising edge.
    bit compare_on = 1'b0;
    always @(posedge clk) begin
        #1;
        if (compare_on) chk_all("model", expected());
    end

    task automatic drive(input txn_t t);
        read_data_in      = t.rdat;
        alu_result_in     = t.alu;
        rd_mem_in         = t.rd;
        reg_write_mem_in  = t.rw;
        mem_to_reg_mem_in = t.m2r;
    endtask

    initial begin
        txn_t t;
        compare_on = 1'b1;

        // Reset before any clock edge with nonzero inputs
        drive('{rdat: 32'h1111_2222, alu: 32'h3333_4444, rd: 5'd7, rw: 1'b1, m2r: 1'b1});
        #1 rst = 1'b1;
        #1 chk_all("reset0", '0);
        chk("reset0.wb_en_lit", {31'd0, wb_en_out}, 32'd0);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive('{rdat: 32'hCAFE_BABE, alu: 32'hDEAD_BEEF, rd: 5'd12, rw: 1'b1, m2r: 1'b1});
        @(posedge clk); #1;
        chk("t2.read_data", read_data_out, 32'hCAFE_BABE);
        chk("t2.alu", alu_result_out, 32'hDEAD_BEEF);
        chk("t2.rd", {27'd0, rd_mem_out}, 32'd12);
        chk("t2.ctrl", {30'd0, reg_write_mem_out, mem_to_reg_mem_out}, 32'd3);
        chk("t2.wb_data", wb_data_out, 32'hCAFE_BABE);
        chk("t2.wb_en", {31'd0, wb_en_out}, 32'd1);

        @(negedge clk);
        mem_to_reg_mem_in = 1'b0;
        @(posedge clk); #1;
        chk("t3.wb_data", wb_data_out, 32'hDEAD_BEEF);

        // Mid-cycle change must not disturb outputs until the next edge
        @(negedge clk);
        drive('{rdat: 32'h0BAD_F00D, alu: 32'h1234_5678, rd: 5'd0, rw: 1'b1, m2r: 1'b0});
        #1;
        chk("t3.hold_wb", wb_data_out, 32'hDEAD_BEEF);
        chk("t3.hold_rd", {27'd0, rd_mem_out}, 32'd12);
        @(posedge clk); #1;
        chk("t4.rd", {27'd0, rd_mem_out}, 32'd0);
        chk("t4.reg_write", {31'd0, reg_write_mem_out}, 32'd1);
        chk("t4.wb_en", {31'd0, wb_en_out}, 32'd0);
        chk("t4.wb_data", wb_data_out, 32'h1234_5678);

        // Asynchronous reset 2 ns after an edge with loaded state
        @(negedge clk);
        drive('{rdat: 32'hA5A5_A5A5, alu: 32'h5A5A_5A5A, rd: 5'd31, rw: 1'b1, m2r: 1'b1});
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t5.rd_async", {27'd0, rd_mem_out}, 32'd0);
        chk("t5.wb_data_async", wb_data_out, 32'd0);
        chk("t5.wb_en_async", {31'd0, wb_en_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive('{rdat: 32'h0000_0042, alu: 32'h0000_0099, rd: 5'd3, rw: 1'b1, m2r: 1'b0});
        @(posedge clk); #1;
        chk("t5.reload_wb", wb_data_out, 32'h0000_0099);
        chk("t5.reload_rd", {27'd0, rd_mem_out}, 32'd3);

        // Back-to-back rd = 1..8
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            t.rdat = $urandom; t.alu = $urandom; t.rd = 5'(k);
            t.rw = 1'b1; t.m2r = 1'($urandom_range(0, 1));
            drive(t);
            @(posedge clk); #1;
            chk("t6.rd_track", {27'd0, rd_mem_out}, 32'(k));
        end

        // Random traffic with occasional resets
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            t.rdat = $urandom; t.alu = $urandom; t.rd = 5'($urandom_range(0, 31));
            t.rw = 1'($urandom_range(0, 1)); t.m2r = 1'($urandom_range(0, 1));
            drive(t);
            rst = ($urandom_range(0, 19) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #2;
        compare_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
